// File: rtl/fp_pipe_stage.sv
// Ready/valid pipeline stage for unpacked FP operands with optional skid buffer.
// Define FP_PIPE_STAGE_SKID_EN to add the skid register and a fully registered in_ready.
module fp_pipe_stage #(
  parameter int FRAC_W = 28,
  parameter int EXP_W  = 8,
  parameter int NAN_W  = 23
) (
  input  logic              clock,
  input  logic              clr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_rm,
  input  logic              in_is_inf_nan,
  input  logic [NAN_W-1:0]  in_inf_nan_frac,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [FRAC_W-1:0] in_frac,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_rm,
  output logic              out_is_inf_nan,
  output logic [NAN_W-1:0]  out_inf_nan_frac,
  output logic              out_sign,
  output logic [EXP_W-1:0]  out_exp,
  output logic [FRAC_W-1:0] out_frac,
  output logic [1:0]        count
);

  localparam int PW = 2 + 1 + NAN_W + 1 + EXP_W + FRAC_W;

  logic [PW-1:0] w_in_pl;
  logic [PW-1:0] r_m_pl;
  logic          r_m_valid;
  logic          w_accept;
  logic          w_deliver;

  assign w_in_pl = {in_rm, in_is_inf_nan, in_inf_nan_frac, in_sign, in_exp, in_frac};
  assign {out_rm, out_is_inf_nan, out_inf_nan_frac, out_sign, out_exp, out_frac} = r_m_pl;
  assign out_valid = r_m_valid;

  // A flush cycle never counts as a transfer on either side.
  assign w_accept  = in_valid & in_ready & ~flush;
  assign w_deliver = r_m_valid & out_ready & ~flush;

`ifdef FP_PIPE_STAGE_SKID_EN
  logic [PW-1:0] r_s_pl;
  logic          r_s_valid;

  // Only gated by clr; no path from out_ready.
  assign in_ready = ~r_s_valid & ~clr;
  assign count    = {r_m_valid & r_s_valid, r_m_valid ^ r_s_valid};

  always_ff @(posedge clock) begin
    if (clr) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
      r_m_pl    <= '0;
      r_s_pl    <= '0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
      r_s_valid <= 1'b0;
    end else if (w_deliver) begin
      if (r_s_valid) begin
        r_m_pl    <= r_s_pl;
        r_s_valid <= 1'b0;
      end else if (w_accept) begin
        r_m_pl <= w_in_pl;
      end else begin
        r_m_valid <= 1'b0;
      end
    end else if (w_accept) begin
      if (!r_m_valid) begin
        r_m_pl    <= w_in_pl;
        r_m_valid <= 1'b1;
      end else begin
        r_s_pl    <= w_in_pl;
        r_s_valid <= 1'b1;
      end
    end
  end
`else
  assign in_ready = (~r_m_valid | out_ready) & ~clr;
  assign count    = {1'b0, r_m_valid};

  always_ff @(posedge clock) begin
    if (clr) begin
      r_m_valid <= 1'b0;
      r_m_pl    <= '0;
    end else if (flush) begin
      r_m_valid <= 1'b0;
    end else if (w_accept) begin
      r_m_pl    <= w_in_pl;
      r_m_valid <= 1'b1;
    end else if (w_deliver) begin
      r_m_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fp_pipe_stage.sv
// Self-checking bench for fp_pipe_stage: directed vector table, corner sequences,
// and a queue-model scoreboard under random traffic (adapts to FP_PIPE_STAGE_SKID_EN).
module tb_fp_pipe_stage;

  localparam int FRAC_W = 28;
  localparam int EXP_W  = 8;
  localparam int NAN_W  = 23;
  localparam int PW     = 2 + 1 + NAN_W + 1 + EXP_W + FRAC_W;

  logic              clock = 1'b0;
  logic              clr, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]        in_rm, out_rm, count;
  logic              in_is_inf_nan, out_is_inf_nan, in_sign, out_sign;
  logic [NAN_W-1:0]  in_inf_nan_frac, out_inf_nan_frac;
  logic [EXP_W-1:0]  in_exp, out_exp;
  logic [FRAC_W-1:0] in_frac, out_frac;
  logic [PW-1:0]     d_pl, o_pl;

  int n_cmp = 0;
  int n_bad = 0;

  assign {in_rm, in_is_inf_nan, in_inf_nan_frac, in_sign, in_exp, in_frac} = d_pl;
  assign o_pl = {out_rm, out_is_inf_nan, out_inf_nan_frac, out_sign, out_exp, out_frac};

  fp_pipe_stage #(.FRAC_W(FRAC_W), .EXP_W(EXP_W), .NAN_W(NAN_W)) dut (
    .clock(clock), .clr(clr), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rm(in_rm), .in_is_inf_nan(in_is_inf_nan), .in_inf_nan_frac(in_inf_nan_frac),
    .in_sign(in_sign), .in_exp(in_exp), .in_frac(in_frac),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rm(out_rm), .out_is_inf_nan(out_is_inf_nan), .out_inf_nan_frac(out_inf_nan_frac),
    .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac),
    .count(count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        clr, flush, iv;
    logic [7:0]  exp;
    logic [27:0] frac;
    logic        ordy;
    logic        e_rdy, e_ov;
    logic [7:0]  e_exp;
    logic [27:0] e_frac;
    logic [1:0]  e_cnt;
  } vec_t;

  // Full payload derived from exp/frac so an all-zero exp means an all-zero entry.
  function automatic logic [PW-1:0] mk(input logic [7:0] e, input logic [27:0] f);
    return {e[1:0], e[2], e, e, e[6:0], e[7], e, f};
  endfunction

  function automatic logic [PW-1:0] rnd();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[PW-1:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input logic c, input logic f, input logic v,
                       input logic [PW-1:0] p, input logic r);
    clr = c; flush = f; in_valid = v; d_pl = p; out_ready = r;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_out(input string nm, input logic ov, input logic [PW-1:0] p,
                         input logic [1:0] c);
    chk({nm, "_ov"}, 64'(out_valid), 64'(ov));
    chk({nm, "_pl"}, 64'(o_pl), 64'(p));
    chk({nm, "_cnt"}, 64'(count), 64'(c));
  endtask

  vec_t tbl[10];
  logic [PW-1:0] q[$];

  initial begin
    logic [PW-1:0] pa, pb, pc, pd, pe, pf, pend;
    int n_acc, n_cyc;
    logic iv, ordy, fl, pr;

    tbl[0] = '{1, 0, 0, 8'h00, 28'h0,       0, 0, 0, 8'h00, 28'h0,       2'd0};
    tbl[1] = '{0, 0, 1, 8'h7F, 28'h0800000, 1, 1, 1, 8'h7F, 28'h0800000, 2'd1};
    tbl[2] = '{0, 0, 1, 8'h01, 28'h1,       1, 1, 1, 8'h01, 28'h1,       2'd1};
    tbl[3] = '{0, 0, 0, 8'h00, 28'h0,       1, 1, 0, 8'h01, 28'h1,       2'd0};
    tbl[4] = '{0, 0, 1, 8'h22, 28'hABC,     0, 1, 1, 8'h22, 28'hABC,     2'd1};
    tbl[5] = '{0, 1, 1, 8'h33, 28'h333,     1, 1, 0, 8'h22, 28'hABC,     2'd0};
    tbl[6] = '{0, 0, 0, 8'h00, 28'h0,       1, 1, 0, 8'h22, 28'hABC,     2'd0};
    tbl[7] = '{0, 0, 1, 8'h44, 28'h444,     0, 1, 1, 8'h44, 28'h444,     2'd1};
    tbl[8] = '{1, 0, 1, 8'h55, 28'h555,     0, 0, 0, 8'h00, 28'h0,       2'd0};
    tbl[9] = '{0, 0, 0, 8'h00, 28'h0,       0, 1, 0, 8'h00, 28'h0,       2'd0};

    apply(1, 0, 0, '0, 0);
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].clr, tbl[i].flush, tbl[i].iv, mk(tbl[i].exp, tbl[i].frac), tbl[i].ordy);
      #1;
      chk($sformatf("tbl%0d_rdy", i), 64'(in_ready), 64'(tbl[i].e_rdy));
      cyc();
      chk_out($sformatf("tbl%0d", i), tbl[i].e_ov, mk(tbl[i].e_exp, tbl[i].e_frac), tbl[i].e_cnt);
    end

    pa = rnd(); pb = rnd(); pc = rnd(); pd = rnd(); pe = rnd(); pf = rnd();
`ifdef FP_PIPE_STAGE_SKID_EN
    // Back-pressure fills M then S; C waits upstream, then drains in order.
    apply(0, 0, 1, pa, 0); cyc(); chk_out("bp_a", 1, pa, 2'd1);
    apply(0, 0, 1, pb, 0); cyc(); chk_out("bp_b", 1, pa, 2'd2);
    apply(0, 0, 1, pc, 0); #1; chk("bp_c_rdy", 64'(in_ready), 64'(0));
    cyc(); chk_out("bp_c", 1, pa, 2'd2);
    apply(0, 0, 1, pc, 1); #1; chk("dr1_rdy", 64'(in_ready), 64'(0));
    cyc(); chk_out("dr1", 1, pb, 2'd1);
    #1; chk("dr2_rdy", 64'(in_ready), 64'(1));
    cyc(); chk_out("dr2", 1, pc, 2'd1);
    apply(0, 0, 0, pc, 1); cyc(); chk_out("dr3", 0, pc, 2'd0);
    cyc(); chk_out("dr4", 0, pc, 2'd0);
    // Flush at full occupancy drops everything, including the offered F.
    apply(0, 0, 1, pd, 0); cyc();
    apply(0, 0, 1, pe, 0); cyc(); chk_out("fl_full", 1, pd, 2'd2);
    apply(0, 1, 1, pf, 0); cyc(); chk_out("fl", 0, pd, 2'd0);
    apply(0, 0, 0, pf, 1); cyc(); cyc(); chk_out("fl_after", 0, pd, 2'd0);
    // clr beats flush at full occupancy.
    apply(0, 0, 1, pd, 0); cyc();
    apply(0, 0, 1, pe, 0); cyc(); chk_out("clr_full", 1, pd, 2'd2);
`else
    apply(0, 0, 1, pa, 0); cyc(); chk_out("bp_a", 1, pa, 2'd1);
    apply(0, 0, 1, pb, 0); #1; chk("bp_b_rdy", 64'(in_ready), 64'(0));
    cyc(); chk_out("bp_b", 1, pa, 2'd1);
    apply(0, 0, 1, pb, 1); #1; chk("pass_rdy", 64'(in_ready), 64'(1));
    cyc(); chk_out("pass", 1, pb, 2'd1);
    apply(0, 0, 0, pb, 1); cyc(); chk_out("empty", 0, pb, 2'd0);
    apply(0, 0, 1, pd, 0); cyc();
    apply(0, 1, 1, pf, 1); cyc(); chk_out("fl", 0, pd, 2'd0);
    apply(0, 0, 0, pf, 1); cyc(); chk_out("fl_after", 0, pd, 2'd0);
    apply(0, 0, 1, pd, 0); cyc(); chk_out("clr_full", 1, pd, 2'd1);
`endif
    apply(1, 1, 1, pf, 0); #1; chk("clr_rdy", 64'(in_ready), 64'(0));
    cyc(); chk_out("clr", 0, '0, 2'd0);
    chk("clr_rdy_hold", 64'(in_ready), 64'(0));
    apply(0, 0, 0, '0, 0); #1; chk("rel_rdy", 64'(in_ready), 64'(1));
    cyc();

    // Random traffic against a queue model of held entries.
    n_acc = 0; n_cyc = 0;
    pend = rnd();
    while (n_acc < 10000 && n_cyc < 60000) begin
      chk("rnd_ov", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) chk("rnd_pl", 64'(o_pl), 64'(q[0]));
      chk("rnd_cnt", 64'(count), 64'(q.size()));
      iv   = 1'($urandom_range(0, 1));
      ordy = 1'($urandom_range(0, 1));
      fl   = ($urandom_range(0, 63) == 0);
      apply(0, fl, iv, pend, ordy);
      #1;
`ifdef FP_PIPE_STAGE_SKID_EN
      pr = (q.size() < 2);
      chk("rnd_rdy", 64'(in_ready), 64'(pr));
      out_ready = ~ordy;
      #1;
      chk("rnd_comb_path", 64'(in_ready), 64'(pr));
      out_ready = ordy;
`else
      pr = (q.size() == 0) || ordy;
      chk("rnd_rdy", 64'(in_ready), 64'(pr));
`endif
      if (fl) begin
        q.delete();
        if (iv) pend = rnd();
      end else begin
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (iv && pr) begin
          q.push_back(pend);
          n_acc++;
          pend = rnd();
        end
      end
      cyc();
      n_cyc++;
    end
    if (n_acc < 10000) begin
      n_cmp++; n_bad++;
      $display("FAIL rnd_budget: got %0d accepted want 10000", n_acc);
    end
    for (int k = 0; k < 4; k++) begin
      chk("drain_ov", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) chk("drain_pl", 64'(o_pl), 64'(q[0]));
      chk("drain_cnt", 64'(count), 64'(q.size()));
      apply(0, 0, 0, pend, 1);
      if (q.size() > 0) void'(q.pop_front());
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_pipe_stage.md
FP_PIPE_STAGE -- requirements
Module: fp_pipe_stage

Interface
REQ-001 Parameter FRAC_W, default 28, significand field width.
REQ-002 Parameter EXP_W, default 8, exponent field width.
REQ-003 Parameter NAN_W, default 23, inf/NaN fraction field width.
REQ-004 Reset is synchronous and active-high: `clr` is sampled only on the rising edge of `clock`.
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 clr  input  1  synchronous active-high reset.
REQ-007 flush  input  1  discards all held entries.
REQ-008 in_valid  input  1  upstream holds a valid entry.
REQ-009 in_ready  output  1  stage can accept an entry this cycle.
REQ-010 in_rm / out_rm  input / output  2  rounding mode.
REQ-011 in_is_inf_nan / out_is_inf_nan  input / output  1  special-value flag.
REQ-012 in_inf_nan_frac / out_inf_nan_frac  input / output  NAN_W  special-value fraction.
REQ-013 in_sign / out_sign  input / output  1  sign.
REQ-014 in_exp / out_exp  input / output  EXP_W  exponent.
REQ-015 in_frac / out_frac  input / output  FRAC_W  significand.
REQ-016 out_valid  output  1  out_* fields hold a valid entry.
REQ-017 out_ready  input  1  downstream accepts the entry this cycle.
REQ-018 count  output  2  occupancy, range 0..2.

Function
REQ-019 Accept = in_valid & in_ready; deliver = out_valid & out_ready; each entry is delivered once, in order, payload unmodified.
REQ-020 Storage consists of a main register M driving out_* and a skid register S; out_valid = M.valid.
REQ-021 in_ready = !S.valid, driven from a register with no combinational path from out_ready.
REQ-022 If deliver and S.valid: M <= S and S becomes empty; in_ready is 0 in that cycle, so nothing is accepted.
REQ-023 If deliver, !S.valid and accept: M <= in and occupancy stays 1.
REQ-024 If deliver with no accept: M becomes empty.
REQ-025 With no deliver: on accept, M <= in if M is empty, else S <= in.
REQ-026 While out_valid=1 and out_ready=0, out_* hold their value.
REQ-027 Flush has priority over accept and deliver: M.valid and S.valid clear next cycle, and any entry offered in the flush cycle is dropped.
REQ-028 During flush, in_ready and out_valid may still be 1, but no transfer counts.
REQ-029 Payload registers are not cleared by flush.
REQ-030 count = M.valid + S.valid, registered.
REQ-031 Latency: an accepted entry appears on out_* the cycle after acceptance when M is empty; sustained throughput is 1 entry per cycle.

Reset
REQ-032 While clr=1 at a clock edge, the next state is: M.valid=0, S.valid=0, all out_* = 0, count = 0.
REQ-033 While clr=1, in_ready=0 and inputs are ignored.
REQ-034 In the first cycle after clr deasserts, in_ready=1.
REQ-035 clr asserted mid-transfer drops all held entries, with no partial update.
REQ-036 clr has priority over flush.

Configuration
REQ-037 Macro FP_PIPE_STAGE_SKID_EN defined: S is present and behaviour is per REQ-020..REQ-031.
REQ-038 FP_PIPE_STAGE_SKID_EN undefined: S is absent; in_ready = !out_valid | out_ready (combinational) and count never exceeds 1.
REQ-039 FP_PIPE_STAGE_SKID_EN undefined: ordering, flush and reset are unchanged, and throughput is still 1 per cycle when out_ready=1.

Verification
REQ-040 Reset, then in_valid=1 with exp=8'h7F, frac=28'h0800000, out_ready=1 -> next cycle out_valid=1, out_exp=8'h7F, out_frac=28'h0800000, count=1.
REQ-041 out_ready=0, three back-to-back offers A,B,C -> A in M, B in S, in_ready=0 in the third cycle, C held upstream; count=2.
REQ-042 Then out_ready=1 for 4 cycles -> A,B,C delivered in order, one per cycle; count returns to 0.
REQ-043 count=2, flush=1 with in_valid=1 -> next cycle out_valid=0, count=0, offered entry never delivered.
REQ-044 clr=1 while count=2 and flush=1 -> out_* all 0, in_ready=0 during clr; in_ready=1 the cycle after release.
REQ-045 Random in_valid/out_ready at 50% each, 10000 entries, both macro settings -> scoreboard shows no loss, duplication or reordering, and no combinational out_ready->in_ready path with the macro defined.
